// File: rtl/enc_8b10b.sv
// 8b/10b encoder with running-disparity tracking and a one-deep valid/ready output register.
// Symbols are emitted abcdei_fghj with data_out[9] = a and data_out[0] = j.
module enc_8b10b #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       k_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [9:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       rd_out,
    output logic       k_error
);

    logic [4:0] x_val;
    logic [2:0] y_val;
    logic       is_k28;
    logic       k_supported;
    logic [5:0] code6_neg;
    logic [5:0] code6;
    logic       unbal6;
    logic       rd6;
    logic       use_alt7;
    logic [3:0] code4_neg;
    logic [3:0] code4;
    logic       unbal4;
    logic       rd_next;
    logic       accept;

    // 5b/6b sub-block as seen at RD-; the RD+ form is derived by complementing.
    function automatic logic [5:0] code6_rd_neg(input logic [4:0] v);
        logic [5:0] c;
        case (v)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b sub-block as seen at RD-, before K28 and alternate-7 adjustments.
    function automatic logic [3:0] code4_rd_neg(input logic [2:0] v);
        logic [3:0] c;
        case (v)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    assign ready_out = ~valid_out | ready_in;
    assign accept    = valid_in & ready_out;

    // D.07 and D.x.3 are balanced yet still swap form with disparity, and every
    // K28 fghj swaps, which is what gives K28.1/2/5/6 their inverted balanced forms.
    always_comb begin
        x_val       = data_in[4:0];
        y_val       = data_in[7:5];
        is_k28      = k_in && (x_val == 5'd28);
        k_supported = is_k28 ||
                      (k_in && (y_val == 3'd7) &&
                       ((x_val == 5'd23) || (x_val == 5'd27) ||
                        (x_val == 5'd29) || (x_val == 5'd30)));

        code6_neg = is_k28 ? 6'b001111 : code6_rd_neg(x_val);
        unbal6    = ($countones(code6_neg) != 3);
        code6     = (rd_out && (unbal6 || (!is_k28 && (x_val == 5'd7)))) ? ~code6_neg : code6_neg;
        rd6       = rd_out ^ unbal6;

        use_alt7 = (y_val == 3'd7) &&
                   (k_supported ||
                    (!rd6 && ((x_val == 5'd17) || (x_val == 5'd18) || (x_val == 5'd20))) ||
                    ( rd6 && ((x_val == 5'd11) || (x_val == 5'd13) || (x_val == 5'd14))));

        code4_neg = code4_rd_neg(y_val);
        if (use_alt7) begin
            code4_neg = 4'b0111;
        end else if (is_k28 && ((y_val == 3'd1) || (y_val == 3'd2) ||
                                (y_val == 3'd5) || (y_val == 3'd6))) begin
            code4_neg = ~code4_neg;
        end
        unbal4  = ($countones(code4_neg) != 2);
        code4   = (rd6 && (unbal4 || (y_val == 3'd3) || is_k28)) ? ~code4_neg : code4_neg;
        rd_next = rd6 ^ unbal4;
    end

    // Output register: load on accept, drop valid on a consume without a new accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= 10'b0;
            k_error   <= 1'b0;
            rd_out    <= RD_INIT;
        end else if (accept) begin
            valid_out <= 1'b1;
            data_out  <= {code6, code4};
            k_error   <= k_in & ~k_supported;
            rd_out    <= rd_next;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enc_8b10b.sv
// Scoreboard bench for enc_8b10b: table-driven reference model, random D/K stream,
// directed stall and asynchronous-reset scenarios.
module tb_enc_8b10b;

    localparam logic RD_INIT = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       k_in;
    logic       valid_in;
    logic       ready_out;
    logic [9:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       rd_out;
    logic       k_error;

    enc_8b10b #(.RD_INIT(RD_INIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .k_in      (k_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .rd_out    (rd_out),
        .k_error   (k_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       kerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic model_rd;
    logic rand_ready;
    logic run_bit;
    int   run_len;

    logic [5:0] six_neg [32];
    logic [5:0] six_pos [32];
    logic [3:0] d4_neg  [8];
    logic [3:0] d4_pos  [8];
    logic [3:0] k4_neg  [8];
    logic [3:0] k4_pos  [8];
    logic [7:0] kcodes  [12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Disparity after a sub-block: more ones pushes RD+, fewer pushes RD-, balanced keeps it.
    function automatic logic next_rd(input logic rd_in, input int ones, input int half);
        if (ones > half) return 1'b1;
        if (ones < half) return 1'b0;
        return rd_in;
    endfunction

    function automatic void model_encode(input logic [7:0] d, input logic k, input logic rd_in,
                                         output logic [9:0] sym, output logic rd_o, output logic kerr);
        int         x;
        int         y;
        logic       sup;
        logic       k28;
        logic       alt;
        logic       rd6;
        logic [5:0] s6;
        logic [3:0] f4;
        x    = int'(d[4:0]);
        y    = int'(d[7:5]);
        k28  = k && (x == 28);
        sup  = k28 || (k && (y == 7) && (x == 23 || x == 27 || x == 29 || x == 30));
        kerr = k && !sup;
        if (k28) s6 = rd_in ? 6'b110000 : 6'b001111;
        else     s6 = rd_in ? six_pos[x] : six_neg[x];
        rd6 = next_rd(rd_in, $countones(s6), 3);
        alt = (y == 7) && (sup || (!rd6 && (x == 17 || x == 18 || x == 20)) ||
                                  ( rd6 && (x == 11 || x == 13 || x == 14)));
        if (k28)      f4 = rd6 ? k4_pos[y] : k4_neg[y];
        else if (alt) f4 = rd6 ? 4'b1000 : 4'b0111;
        else          f4 = rd6 ? d4_pos[y] : d4_neg[y];
        rd_o = next_rd(rd6, $countones(f4), 2);
        sym  = {s6, f4};
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic k, input logic use_exp,
                                 input logic [9:0] exp_sym, input logic exp_rd, input logic exp_kerr);
        exp_t e;
        logic acc;
        int   waited;
        if (use_exp) begin
            e.sym  = exp_sym;
            e.rd   = exp_rd;
            e.kerr = exp_kerr;
        end else begin
            model_encode(d, k, model_rd, e.sym, e.rd, e.kerr);
        end
        valid_in = 1'b1;
        data_in  = d;
        k_in     = k;
        acc      = 1'b0;
        waited   = 0;
        while (!acc && waited < 1000) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            waited++;
        end
        if (acc) begin
            exp_q.push_back(e);
            model_rd = e.rd;
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: actual=no_accept required=accept data=%0h", d);
        end
        valid_in = 1'b0;
    endtask

    task automatic drainOutputs();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: actual=%0d pending required=0 pending", exp_q.size());
        end
    endtask

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops one expectation per consumed symbol and checks disparity and run length.
    initial begin : monitor
        exp_t e;
        int   max_run;
        run_len = 0;
        run_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run_len = 0;
            end else begin
                checkOutput("ready_out", {31'b0, ready_out}, {31'b0, (!valid_out || ready_in)});
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_symbol: actual=%b required=none", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("data_out", {22'b0, data_out}, {22'b0, e.sym});
                        checkOutput("rd_out", {31'b0, rd_out}, {31'b0, e.rd});
                        checkOutput("k_error", {31'b0, k_error}, {31'b0, e.kerr});
                        checkOutput("symbol_disparity_ok",
                                    {31'b0, ($countones(data_out) >= 4 && $countones(data_out) <= 6)}, 1);
                        max_run = 0;
                        for (int i = 9; i >= 0; i--) begin
                            if (run_len > 0 && data_out[i] == run_bit) begin
                                run_len++;
                            end else begin
                                run_bit = data_out[i];
                                run_len = 1;
                            end
                            if (run_len > max_run) max_run = run_len;
                        end
                        checkOutput("run_length_le5", {31'b0, (max_run <= 5)}, 1);
                    end
                end
            end
        end
    end

    initial begin : main
        logic [7:0] d;
        logic       k;
        int         r;
        six_neg = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        six_pos = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
        d4_neg  = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        d4_pos  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
        k4_neg  = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
        k4_pos  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
        kcodes  = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

        reset      = 1'b0;
        valid_in   = 1'b0;
        data_in    = 8'h00;
        k_in       = 1'b0;
        ready_in   = 1'b1;
        rand_ready = 1'b0;
        model_rd   = RD_INIT;

        #1;
        checkOutput("reset_valid_out", {31'b0, valid_out}, 0);
        checkOutput("reset_data_out", {22'b0, data_out}, 0);
        checkOutput("reset_k_error", {31'b0, k_error}, 0);
        checkOutput("reset_rd_out", {31'b0, rd_out}, {31'b0, RD_INIT});
        checkOutput("reset_ready_out", {31'b0, ready_out}, 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] directed encodings");
        applyStimulus(8'h00, 1'b0, 1'b1, 10'b1001110100, 1'b0, 1'b0);
        applyStimulus(8'hBC, 1'b1, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        applyStimulus(8'hBC, 1'b1, 1'b1, 10'b1100000101, 1'b0, 1'b0);
        applyStimulus(8'hF1, 1'b0, 1'b1, 10'b1000110111, 1'b1, 1'b0);
        applyStimulus(8'hB5, 1'b0, 1'b1, 10'b1010101010, 1'b1, 1'b0);
        applyStimulus(8'hBC, 1'b1, 1'b1, 10'b1100000101, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b1, 10'b1001110100, 1'b0, 1'b1);
        applyStimulus(8'hBC, 1'b1, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        drainOutputs();

        $display("[TB] stall with pending input");
        ready_in = 1'b0;
        applyStimulus(8'h4A, 1'b0, 1'b1, 10'b0101010101, 1'b1, 1'b0);
        valid_in = 1'b1;
        data_in  = 8'h00;
        k_in     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_ready_out", {31'b0, ready_out}, 0);
            checkOutput("stall_valid_out", {31'b0, valid_out}, 1);
            checkOutput("stall_data_out", {22'b0, data_out}, {22'b0, 10'b0101010101});
            checkOutput("stall_rd_out", {31'b0, rd_out}, 1);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b1, 10'b0110001011, 1'b1, 1'b0);
        drainOutputs();

        $display("[TB] reset during stalled symbol");
        ready_in = 1'b0;
        applyStimulus(8'h55, 1'b0, 1'b0, 10'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_valid_out", {31'b0, valid_out}, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_valid_out", {31'b0, valid_out}, 0);
        checkOutput("async_reset_rd_out", {31'b0, rd_out}, {31'b0, RD_INIT});
        checkOutput("async_reset_data_out", {22'b0, data_out}, 0);
        checkOutput("async_reset_k_error", {31'b0, k_error}, 0);
        checkOutput("async_reset_ready_out", {31'b0, ready_out}, 1);
        exp_q.delete();
        model_rd = RD_INIT;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;

        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                d = kcodes[$urandom_range(0, 11)];
                k = 1'b1;
            end else if (r == 1) begin
                d = 8'($urandom);
                k = 1'b1;
            end else begin
                d = 8'($urandom);
                k = 1'b0;
            end
            applyStimulus(d, k, 1'b0, 10'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #2;
        rand_ready = 1'b0;
        ready_in   = 1'b1;
        drainOutputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
